opcode_selector: RTL and testbench



---
 rtl/opcode_selector.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_opcode_selector.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/opcode_selector.sv
// opcode_selector: operator-side encoder for the opcode display path.
// Three raw push-buttons (next/prev/confirm) are synchronized and edge
// detected. They step a display selection through codes 01..10 and commit
// the matching opcode index with a one-cycle valid pulse.
// Optional build macro: DEBOUNCE_EN inserts a per-button debouncer of
// DEBOUNCE_CYCLES stable cycles between the synchronizer and the edge
// detector. The default build has no debouncer.

module opcode_selector #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       next_i,
  input  logic       prev_i,
  input  logic       confirm_i,
  output logic [3:0] tens_o,
  output logic [3:0] units_o,
  output logic [3:0] opcode_o,
  output logic       opcode_valid_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    ST_SELECT = 2'd0,
    ST_COMMIT = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  // Button bit positions inside the conditioned vectors.
  localparam int BTN_NEXT = 0;
  localparam int BTN_PREV = 1;
  localparam int BTN_CONF = 2;

  // The arming counter covers the cycles after reset in which the
  // synchronizer pipeline is still refilling from the raw pins.
  localparam logic [1:0] ARM_DONE = 2'd2;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Display code (1..10) to opcode index. 8 and 10..13, 15 are never produced.
  function automatic logic [3:0] encode_opcode(input logic [3:0] sel);
    logic [3:0] idx;
    case (sel)
      4'd1:    idx = 4'd0;
      4'd2:    idx = 4'd1;
      4'd3:    idx = 4'd2;
      4'd4:    idx = 4'd3;
      4'd5:    idx = 4'd4;
      4'd6:    idx = 4'd5;
      4'd7:    idx = 4'd6;
      4'd8:    idx = 4'd7;
      4'd9:    idx = 4'd9;
      4'd10:   idx = 4'd14;
      default: idx = 4'd0;
    endcase
    return idx;
  endfunction

  // Step up with wrap 10 -> 1. Out-of-range values recover to 1.
  function automatic logic [3:0] sel_inc(input logic [3:0] sel);
    logic [3:0] res;
    if ((sel >= 4'd10) || (sel == 4'd0)) begin
      res = 4'd1;
    end else begin
      res = sel + 4'd1;
    end
    return res;
  endfunction

  // Step down with wrap 1 -> 10. Out-of-range values recover to 10.
  function automatic logic [3:0] sel_dec(input logic [3:0] sel);
    logic [3:0] res;
    if ((sel <= 4'd1) || (sel > 4'd10)) begin
      res = 4'd10;
    end else begin
      res = sel - 4'd1;
    end
    return res;
  endfunction

  // Tens digit of a selection in 1..10.
  function automatic logic [3:0] tens_of(input logic [3:0] sel);
    logic [3:0] res;
    if (sel >= 4'd10) begin
      res = 4'd1;
    end else begin
      res = 4'd0;
    end
    return res;
  endfunction

  // Units digit of a selection in 1..10.
  function automatic logic [3:0] units_of(input logic [3:0] sel);
    logic [3:0] res;
    if (sel >= 4'd10) begin
      res = sel - 4'd10;
    end else begin
      res = sel;
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------

  logic [2:0] raw_s;
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;
  logic [2:0] dly_q, dly_d;
  logic [1:0] arm_q, arm_d;
  logic       arming_s;
  logic [2:0] level_s;      // level seen by the edge detector this cycle
  logic [2:0] level_next_s; // value level_s takes after the next edge
  logic [2:0] edge_s;

  assign raw_s    = {confirm_i, prev_i, next_i};
  assign arming_s = (arm_q != ARM_DONE);

`ifdef DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]            filt_q, filt_d;
  logic [2:0][CNT_W-1:0] db_cnt_q, db_cnt_d;

  // Debouncer: accept a new level only after it differs for the full window.
  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (arming_s) begin
        // Track the pipeline while it refills so a held button is not seen
        // as a fresh press once reset is released.
        filt_d[i]   = sync1_q[i];
        db_cnt_d[i] = '0;
      end else if (sync2_q[i] != filt_q[i]) begin
        if (db_cnt_q[i] == CNT_LIMIT) begin
          filt_d[i]   = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          filt_d[i]   = filt_q[i];
          db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
        end
      end else begin
        filt_d[i]   = filt_q[i];
        db_cnt_d[i] = '0;
      end
    end
  end

  // Debouncer state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_q   <= 3'b000;
      db_cnt_q <= '0;
    end else begin
      filt_q   <= filt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign level_s      = filt_q;
  assign level_next_s = filt_d;
`else
  assign level_s      = sync2_q;
  assign level_next_s = sync2_d;
`endif

  assign edge_s = level_s & ~dly_q;

  // Synchronizer, delayed copy and post-reset arming next-state.
  always_comb begin
    sync1_d = raw_s;
    sync2_d = sync1_q;
    if (arming_s) begin
      // Delay copy follows the level it will be compared with, so no edge
      // can appear while the pipeline refills after reset.
      arm_d = arm_q + 2'd1;
      dly_d = level_next_s;
    end else begin
      arm_d = arm_q;
      dly_d = level_s;
    end
  end

  // Synchronizer, delay and arming registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
      dly_q   <= 3'b000;
      arm_q   <= 2'd0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dly_q   <= dly_d;
      arm_q   <= arm_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Selection FSM and registered outputs
  // ---------------------------------------------------------------------------

  state_e     state_q, state_d;
  logic [3:0] sel_q, sel_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;
  logic [3:0] opcode_q, opcode_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;

  // Next state and selection stepping.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ST_SELECT: begin
        if (edge_s[BTN_CONF]) begin
          // Confirm wins over any step edge arriving in the same cycle.
          state_d = ST_COMMIT;
          sel_d   = sel_q;
        end else if (edge_s[BTN_NEXT] && !edge_s[BTN_PREV]) begin
          state_d = ST_SELECT;
          sel_d   = sel_inc(sel_q);
        end else if (edge_s[BTN_PREV] && !edge_s[BTN_NEXT]) begin
          state_d = ST_SELECT;
          sel_d   = sel_dec(sel_q);
        end else begin
          state_d = ST_SELECT;
          sel_d   = sel_q;
        end
      end
      ST_COMMIT: begin
        state_d = ST_HOLD;
        sel_d   = sel_q;
      end
      ST_HOLD: begin
        // Step edges here are dropped; leave once confirm is released.
        sel_d = sel_q;
        if (!level_s[BTN_CONF]) begin
          state_d = ST_SELECT;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_SELECT;
        sel_d   = 4'd1;
      end
    endcase
  end

  // Output next values derived from the upcoming state and selection.
  always_comb begin
    tens_d  = tens_of(sel_d);
    units_d = units_of(sel_d);
    valid_d = (state_d == ST_COMMIT);
    busy_d  = (state_d == ST_COMMIT) || (state_d == ST_HOLD);
    if (state_d == ST_COMMIT) begin
      opcode_d = encode_opcode(sel_q);
    end else begin
      opcode_d = opcode_q;
    end
  end

  // FSM state, selection and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_SELECT;
      sel_q    <= 4'd1;
      tens_q   <= 4'd0;
      units_q  <= 4'd1;
      opcode_q <= 4'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      tens_q   <= tens_d;
      units_q  <= units_d;
      opcode_q <= opcode_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign tens_o         = tens_q;
  assign units_o        = units_q;
  assign opcode_o       = opcode_q;
  assign opcode_valid_o = valid_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_opcode_selector.sv
// Self-checking bench for opcode_selector: cycle model plus directed checks.
module tb_opcode_selector;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       next_i = 1'b0;
  logic       prev_i = 1'b0;
  logic       confirm_i = 1'b0;
  logic [3:0] tens_o, units_o, opcode_o;
  logic       opcode_valid_o, busy_o;

  opcode_selector dut (
    .clk_i(clk_i), .rst_i(rst_i), .next_i(next_i), .prev_i(prev_i),
    .confirm_i(confirm_i), .tens_o(tens_o), .units_o(units_o),
    .opcode_o(opcode_o), .opcode_valid_o(opcode_valid_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Raw levels sampled at every clock edge; a press sampled at edge k-2
  // (and absent at k-3) takes effect at edge k. Levels from before the last
  // reset cannot form an edge.
  localparam int HMAX = 4096;
  logic [2:0] hist [HMAX];
  int  cyc     = 0;
  int  rst_cyc = -1;
  bit  armed   = 1'b0;
  int  m_sel   = 1;
  int  m_mode  = 0;   // 0 selecting, 1 committing, 2 holding
  int  m_opc   = 0;
  int  lut [1:10] = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 14};

  function automatic bit rose(input int b);
    if ((cyc - 3 > rst_cyc) && (cyc < HMAX))
      return hist[cyc-2][b] && !hist[cyc-3][b];
    return 1'b0;
  endfunction

  function automatic bit lvl2(input int b);
    if ((cyc - 2 > rst_cyc) && (cyc < HMAX)) return hist[cyc-2][b];
    return 1'b0;
  endfunction

  always @(posedge clk_i) begin
    bit en, ep, ec;
    if (cyc < HMAX) hist[cyc] = {confirm_i, prev_i, next_i};
    if (rst_i) begin
      armed = 1'b1; rst_cyc = cyc; m_sel = 1; m_mode = 0; m_opc = 0;
    end else if (armed) begin
      en = rose(0); ep = rose(1); ec = rose(2);
      case (m_mode)
        0: begin
          if (ec) begin m_mode = 1; m_opc = lut[m_sel]; end
          else if (en && !ep) m_sel = (m_sel == 10) ? 1 : m_sel + 1;
          else if (ep && !en) m_sel = (m_sel == 1) ? 10 : m_sel - 1;
        end
        1: m_mode = 2;
        2: if (!lvl2(2)) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
    cyc++;
  end

`ifndef DEBOUNCE_EN
  // Per-cycle comparison of every output against the model.
  always @(negedge clk_i) begin
    logic [13:0] e;
    if (armed) begin
      e = {4'(m_sel / 10), 4'(m_sel % 10), 4'(m_opc), (m_mode == 1), (m_mode != 0)};
      check("cycle", 32'({tens_o, units_o, opcode_o, opcode_valid_o, busy_o}), 32'(e));
    end
  end
`endif

  int vcount = 0;
  always @(negedge clk_i) if (opcode_valid_o === 1'b1) vcount++;

  // ---------------- stimulus helpers ----------------
  task automatic set_btn(input logic [2:0] v);
    {confirm_i, prev_i, next_i} = v;
  endtask

  task automatic press(input logic [2:0] base, input logic [2:0] mask, input int hi, input int lo);
    @(posedge clk_i); #1 set_btn(base | mask);
    repeat (hi) @(posedge clk_i);
    #1 set_btn(base);
    repeat (lo) @(posedge clk_i);
  endtask

  task automatic check_disp(input string name, input logic [7:0] exp);
    @(negedge clk_i);
    check(name, 32'({tens_o, units_o}), 32'(exp));
  endtask

  task automatic confirm_and_check(input string name, input logic [3:0] exp_opc);
    int v0;
    v0 = vcount;
    press(3'b000, 3'b100, 4, 8);
    @(negedge clk_i);
    check({name, "_pulses"}, 32'(vcount - v0), 32'd1);
    check({name, "_opcode"}, 32'(opcode_o), 32'(exp_opc));
  endtask

  initial begin
    int v0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_tens", 32'(tens_o), 32'd0);
    check("rst_units", 32'(units_o), 32'd1);
    check("rst_opcode", 32'(opcode_o), 32'd0);
    check("rst_valid", 32'(opcode_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);

`ifdef DEBOUNCE_EN
    press(3'b000, 3'b001, 10, 40);
    check_disp("db_glitch", 8'h01);
    press(3'b000, 3'b001, 20, 40);
    check_disp("db_press", 8'h02);
`else
    repeat (9) press(3'b000, 3'b001, 4, 4);
    check_disp("nine_next", 8'h10);
    press(3'b000, 3'b001, 4, 4);
    check_disp("wrap_up", 8'h01);
    press(3'b000, 3'b010, 4, 4);
    check_disp("wrap_down", 8'h10);
    press(3'b000, 3'b010, 4, 4);
    check_disp("sel9", 8'h09);

    // Confirm 9 with busy observed while the button is still held.
    v0 = vcount;
    @(posedge clk_i); #1 confirm_i = 1'b1;
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    check("hold_busy", 32'(busy_o), 32'd1);
    @(posedge clk_i); #1 confirm_i = 1'b0;
    repeat (8) @(posedge clk_i);
    @(negedge clk_i);
    check("c9_pulses", 32'(vcount - v0), 32'd1);
    check("c9_opcode", 32'(opcode_o), 32'd9);
    check("c9_busy_off", 32'(busy_o), 32'd0);

    press(3'b000, 3'b001, 4, 4);
    confirm_and_check("c10", 4'd14);
    press(3'b000, 3'b010, 4, 4);
    press(3'b000, 3'b010, 4, 4);
    confirm_and_check("c8", 4'd7);

    repeat (3) press(3'b000, 3'b010, 4, 4);
    check_disp("sel5", 8'h05);
    press(3'b000, 3'b011, 4, 4);
    check_disp("next_prev_same", 8'h05);
    press(3'b000, 3'b101, 4, 8);
    @(negedge clk_i);
    check("conf_next_opcode", 32'(opcode_o), 32'd4);
    check_disp("conf_next_disp", 8'h05);
    confirm_and_check("repeat_c5", 4'd4);

    // Steps while holding confirm are discarded.
    @(posedge clk_i); #1 confirm_i = 1'b1;
    repeat (6) @(posedge clk_i);
    repeat (3) press(3'b100, 3'b001, 2, 2);
    @(posedge clk_i); #1 set_btn(3'b000);
    repeat (6) @(posedge clk_i);
    check_disp("hold_ignored", 8'h05);
    press(3'b000, 3'b001, 4, 4);
    check_disp("after_hold", 8'h06);

    // Reset lands on the edge that would enter COMMIT; confirm held through it.
    v0 = vcount;
    @(posedge clk_i); #1 confirm_i = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    check("rstc_pulses", 32'(vcount - v0), 32'd0);
    check("rstc_opcode", 32'(opcode_o), 32'd0);
    check("rstc_busy", 32'(busy_o), 32'd0);
    check_disp("rstc_disp", 8'h01);
    @(posedge clk_i); #1 confirm_i = 1'b0;
    repeat (6) @(posedge clk_i);
    @(negedge clk_i);
    check("rstc_held_pulses", 32'(vcount - v0), 32'd0);
    check("rstc_held_busy", 32'(busy_o), 32'd0);
`endif
    repeat (2) @(posedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
